// File: rtl/mux_2x1_arbiter.sv
// -----------------------------------------------------------------------------
// mux_2x1_arbiter
//   Round-robin, burst-locked arbiter that steers one of two valid/ready
//   requester streams through a 2:1 select into a registered output stage.
//   A grant is held until the granted port's LAST beat is accepted. Between
//   two grants there is always one IDLE cycle.
//
//   Build option:
//     MUX_ARB_BURST_LIMIT_EN  when defined, a grant is also released after
//                             MAX_BURST accepted beats without LAST. The
//                             preempted burst resumes on a later grant.
//
// Parameters
//   WIDTH        data width of both inputs and the output
//   MAX_BURST    beats per grant before forced re-arbitration (2..256);
//                only affects the build with MUX_ARB_BURST_LIMIT_EN
//
// Ports
//   clk_i           clock, rising edge
//   rst_n_i         asynchronous active-low reset
//   in0_valid_i     requester 0 beat valid
//   in0_data_i      requester 0 data
//   in0_last_i      requester 0 final beat of burst
//   in0_ready_o     requester 0 beat accepted when valid & ready
//   in1_valid_i     requester 1 beat valid
//   in1_data_i      requester 1 data
//   in1_last_i      requester 1 final beat of burst
//   in1_ready_o     requester 1 beat accepted when valid & ready
//   out_valid_o     registered output beat valid
//   out_data_o      registered output data
//   out_last_o      registered copy of the source LAST
//   out_src_o       source port of the current output beat
//   out_ready_i     consumer accepts when out_valid_o & out_ready_i
//   select_o        current grant (1 = port 1)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no grant; arbitrate between valid requesters
// BUSY0 | port 0 owns the output until its burst ends
// BUSY1 | port 1 owns the output until its burst ends
// -----------------------------------------------------------------------------
module mux_2x1_arbiter #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in0_valid_i,
    input  logic [WIDTH-1:0] in0_data_i,
    input  logic             in0_last_i,
    output logic             in0_ready_o,
    input  logic             in1_valid_i,
    input  logic [WIDTH-1:0] in1_data_i,
    input  logic             in1_last_i,
    output logic             in1_ready_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_last_o,
    output logic             out_src_o,
    input  logic             out_ready_i,
    output logic             select_o
);

    if (MAX_BURST < 2 || MAX_BURST > 256) begin : g_bad_max_burst
        $error("mux_2x1_arbiter: MAX_BURST must be within 2..256");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY0 = 2'd1,
        S_BUSY1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             rr_q, rr_d;        // 1 = port 1 wins the next contention
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_last_q;
    logic             out_src_q;

    logic             slot_free;
    logic             acc0, acc1, acc, acc_last;
    logic             burst_end;
    logic             cur_port;

    // The output register can take a new beat when empty or being drained.
    assign slot_free   = !out_valid_q || out_ready_i;
    assign in0_ready_o = (state_q == S_BUSY0) && slot_free;
    assign in1_ready_o = (state_q == S_BUSY1) && slot_free;

    assign acc0     = in0_valid_i && in0_ready_o;
    assign acc1     = in1_valid_i && in1_ready_o;
    assign acc      = acc0 || acc1;
    assign acc_last = acc1 ? in1_last_i : in0_last_i;
    assign cur_port = (state_q == S_BUSY1);

`ifdef MUX_ARB_BURST_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(MAX_BURST - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Terminal count on the MAX_BURST-th beat forces release even without LAST.
    assign burst_end = acc && (acc_last || (cnt_q == CNT_TC));

    always_comb begin
        cnt_d = cnt_q;
        if (burst_end) begin
            cnt_d = '0;
        end else if (acc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign burst_end = acc && acc_last;
`endif

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        case (state_q)
            S_IDLE: begin
                if (in0_valid_i && in1_valid_i) begin
                    state_d = rr_q ? S_BUSY1 : S_BUSY0;
                end else if (in0_valid_i) begin
                    state_d = S_BUSY0;
                end else if (in1_valid_i) begin
                    state_d = S_BUSY1;
                end
            end
            S_BUSY0, S_BUSY1: begin
                if (burst_end) begin
                    state_d = S_IDLE;
                    rr_d    = !cur_port;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= 1'b0;
        end else if (acc) begin
            out_valid_q <= 1'b1;
            out_data_q  <= acc1 ? in1_data_i : in0_data_i;
            out_last_q  <= acc_last;
            out_src_q   <= acc1;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign out_src_o   = out_src_q;
    assign select_o    = (state_q == S_BUSY1);

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_2x1_arbiter
//   Directed bench. Each requester is fed from a beat queue that advances
//   only on an observed handshake; every output handshake is logged with its
//   cycle number and compared against hand-written expected sequences.
// -----------------------------------------------------------------------------
module tb_mux_2x1_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in0_valid = 1'b0, in0_last = 1'b0;
    logic         in1_valid = 1'b0, in1_last = 1'b0;
    logic [W-1:0] in0_data = '0, in1_data = '0;
    logic         out_ready = 1'b0;
    logic         in0_ready, in1_ready, out_valid, out_last, out_src, sel;
    logic [W-1:0] out_data;

    typedef struct {
        logic         last;
        logic [W-1:0] data;
    } beat_t;

    typedef struct {
        logic         src;
        logic         last;
        logic [W-1:0] data;
        int           cyc;
    } obs_t;

    beat_t q0[$];
    beat_t q1[$];
    obs_t  obs[$];
    obs_t  exp_q[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_err = 0;
    bit    f0, f1;

    mux_2x1_arbiter #(.WIDTH(W), .MAX_BURST(4)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in0_valid_i (in0_valid),
        .in0_data_i  (in0_data),
        .in0_last_i  (in0_last),
        .in0_ready_o (in0_ready),
        .in1_valid_i (in1_valid),
        .in1_data_i  (in1_data),
        .in1_last_i  (in1_last),
        .in1_ready_o (in1_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_src_o   (out_src),
        .out_ready_i (out_ready),
        .select_o    (sel)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Requester 0: hold the head beat until a handshake is seen.
    initial forever begin
        @(negedge clk); #1;
        f0 = in0_valid && in0_ready;
        @(posedge clk); #1;
        if (f0 && q0.size() > 0) q0.delete(0);
        if (q0.size() > 0) begin
            in0_valid = 1'b1;
            in0_data  = q0[0].data;
            in0_last  = q0[0].last;
        end else begin
            in0_valid = 1'b0;
            in0_last  = 1'b0;
        end
    end

    // Requester 1
    initial forever begin
        @(negedge clk); #1;
        f1 = in1_valid && in1_ready;
        @(posedge clk); #1;
        if (f1 && q1.size() > 0) q1.delete(0);
        if (q1.size() > 0) begin
            in1_valid = 1'b1;
            in1_data  = q1[0].data;
            in1_last  = q1[0].last;
        end else begin
            in1_valid = 1'b0;
            in1_last  = 1'b0;
        end
    end

    // Output monitor: log every beat the consumer takes at the next edge.
    initial forever begin
        @(negedge clk); #1;
        if (out_valid && out_ready) obs.push_back('{out_src, out_last, out_data, cyc});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push0(input logic last, input logic [W-1:0] data);
        q0.push_back('{last, data});
    endtask

    task automatic push1(input logic last, input logic [W-1:0] data);
        q1.push_back('{last, data});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        obs.delete();
        exp_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic expect_beat(input logic src, input logic last, input logic [W-1:0] data);
        exp_q.push_back('{src, last, data, 0});
    endtask

    // Waits for the expected beat count, checks nothing extra arrives, then
    // compares every logged beat against exp_q.
    task automatic check_stream(input string tag);
        int k;
        k = 0;
        while (obs.size() < exp_q.size() && k < 400) begin
            @(negedge clk); #2;
            k++;
        end
        repeat (4) @(negedge clk);
        #2;
        chk($sformatf("%s count", tag), obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            chk($sformatf("%s[%0d] data", tag, i), obs[i].data, exp_q[i].data);
            chk($sformatf("%s[%0d] src", tag, i), obs[i].src, exp_q[i].src);
            chk($sformatf("%s[%0d] last", tag, i), obs[i].last, exp_q[i].last);
        end
    endtask

    task automatic wait_sig(input string tag, input int which);
        int k;
        k = 0;
        while (k < 50 && !((which == 0) ? out_valid : sel)) begin
            @(negedge clk);
            k++;
        end
        chk(tag, (which == 0) ? out_valid : sel, 1'b1);
    endtask

    initial begin
        // Reset state
        @(negedge clk); #1;
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst out_data", out_data, 32'h0);
        chk("rst out_last", out_last, 1'b0);
        chk("rst out_src", out_src, 1'b0);
        chk("rst select", sel, 1'b0);
        chk("rst in0_ready", in0_ready, 1'b0);
        chk("rst in1_ready", in1_ready, 1'b0);
        rst_n = 1'b1;

        // Single 3-beat burst on port 0 at full rate
        do_reset();
        out_ready = 1'b1;
        push0(1'b0, 32'hA0); push0(1'b0, 32'hA1); push0(1'b1, 32'hA2);
        expect_beat(1'b0, 1'b0, 32'hA0);
        expect_beat(1'b0, 1'b0, 32'hA1);
        expect_beat(1'b0, 1'b1, 32'hA2);
        check_stream("burst0");
        if (obs.size() >= 3) begin
            chk("burst0 gap01", obs[1].cyc - obs[0].cyc, 1);
            chk("burst0 gap12", obs[2].cyc - obs[1].cyc, 1);
        end
        chk("burst0 idle select", sel, 1'b0);
        chk("burst0 idle in0_ready", in0_ready, 1'b0);

        // Contention: port 0 first after reset, then round-robin to port 1
        do_reset();
        out_ready = 1'b1;
        push0(1'b0, 32'hB0); push0(1'b1, 32'hB1);
        push0(1'b0, 32'hB2); push0(1'b1, 32'hB3);
        push1(1'b0, 32'hC0); push1(1'b1, 32'hC1);
        expect_beat(1'b0, 1'b0, 32'hB0);
        expect_beat(1'b0, 1'b1, 32'hB1);
        expect_beat(1'b1, 1'b0, 32'hC0);
        expect_beat(1'b1, 1'b1, 32'hC1);
        expect_beat(1'b0, 1'b0, 32'hB2);
        expect_beat(1'b0, 1'b1, 32'hB3);
        check_stream("rr");
        if (obs.size() >= 6) begin
            chk("rr gap inside burst", obs[1].cyc - obs[0].cyc, 1);
            chk("rr bubble 0->1", obs[2].cyc - obs[1].cyc, 2);
            chk("rr bubble 1->0", obs[4].cyc - obs[3].cyc, 2);
        end

        // Back-pressure: output held while out_ready is low
        do_reset();
        out_ready = 1'b0;
        push0(1'b0, 32'h1234); push0(1'b0, 32'h5678); push0(1'b1, 32'h9ABC);
        wait_sig("stall out_valid rises", 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk($sformatf("stall%0d data", i), out_data, 32'h1234);
            chk($sformatf("stall%0d valid", i), out_valid, 1'b1);
            chk($sformatf("stall%0d in0_ready", i), in0_ready, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        expect_beat(1'b0, 1'b0, 32'h1234);
        expect_beat(1'b0, 1'b0, 32'h5678);
        expect_beat(1'b0, 1'b1, 32'h9ABC);
        check_stream("stall");

        // Grant held while port 0 pauses mid-burst and port 1 waits
        do_reset();
        out_ready = 1'b1;
        push0(1'b0, 32'hD0);
        push1(1'b1, 32'hE0);
        begin
            int k;
            k = 0;
            while (q0.size() > 0 && k < 50) begin
                @(negedge clk);
                k++;
            end
            chk("hold D0 accepted", q0.size(), 0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk($sformatf("hold%0d select", i), sel, 1'b0);
            chk($sformatf("hold%0d in1_ready", i), in1_ready, 1'b0);
            chk($sformatf("hold%0d in0_valid low", i), in0_valid, 1'b0);
        end
        push0(1'b1, 32'hD1);
        expect_beat(1'b0, 1'b0, 32'hD0);
        expect_beat(1'b0, 1'b1, 32'hD1);
        expect_beat(1'b1, 1'b1, 32'hE0);
        check_stream("hold");

        // Long port-1 burst with port 0 waiting (MAX_BURST = 4)
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) push1(i == 9, 32'hF000_0000 + 32'(i));
        wait_sig("long select", 1);
        push0(1'b0, 32'h6000_0000); push0(1'b1, 32'h6000_0001);
`ifdef MUX_ARB_BURST_LIMIT_EN
        for (int i = 0; i < 4; i++) expect_beat(1'b1, 1'b0, 32'hF000_0000 + 32'(i));
        expect_beat(1'b0, 1'b0, 32'h6000_0000);
        expect_beat(1'b0, 1'b1, 32'h6000_0001);
        for (int i = 4; i < 10; i++) expect_beat(1'b1, i == 9, 32'hF000_0000 + 32'(i));
`else
        for (int i = 0; i < 10; i++) expect_beat(1'b1, i == 9, 32'hF000_0000 + 32'(i));
        expect_beat(1'b0, 1'b0, 32'h6000_0000);
        expect_beat(1'b0, 1'b1, 32'h6000_0001);
`endif
        check_stream("long");

        // Asynchronous reset in the middle of a stalled port-1 burst
        do_reset();
        out_ready = 1'b0;
        push1(1'b0, 32'h7700); push1(1'b1, 32'h7701);
        wait_sig("midrst out_valid", 0);
        chk("midrst select before", sel, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", out_valid, 1'b0);
        chk("midrst select", sel, 1'b0);
        chk("midrst in0_ready", in0_ready, 1'b0);
        chk("midrst in1_ready", in1_ready, 1'b0);
        q1.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("after rst select", sel, 1'b0);
        chk("after rst out_valid", out_valid, 1'b0);
        chk("after rst in1_ready", in1_ready, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
